// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// State encodings are plain localparams so legacy code can compare against them directly.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 128;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        RESP  = ST_RESP
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on contention the port that did not
// win last time is chosen; a lone request always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the data memory bank (IDLE->ISSUE->RESP).
// Optional address range check enabled by defining DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic [1:0]        state_dbg
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    logic [1:0]        state;
    logic              last;
    logic              winner;
    logic              win_we;
    logic              win_bad;
    logic              err0_q;
    logic              err1_q;

    logic              pick;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_bad;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    always_comb begin
        sel_we    = (pick == PORT1) ? we1    : we0;
        sel_addr  = (pick == PORT1) ? addr1  : addr0;
        sel_wdata = (pick == PORT1) ? wdata1 : wdata0;
        addr_bad  = BOUNDS_EN && (32'(sel_addr) >= 32'(DEPTH));
    end

    assign err0      = err0_q & BOUNDS_EN;
    assign err1      = err1_q & BOUNDS_EN;
    assign state_dbg = state;

    // Bank strobes are live only in ISSUE; readdata is captured on the ISSUE->RESP
    // edge, one full cycle after address was registered, so rdata is valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last      <= PORT1;
            winner    <= PORT0;
            win_we    <= 1'b0;
            win_bad   <= 1'b0;
            memread   <= 1'b0;
            memwrite  <= 1'b0;
            address   <= '0;
            writedata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_ISSUE;
                        last      <= pick;
                        winner    <= pick;
                        win_we    <= sel_we;
                        win_bad   <= addr_bad;
                        address   <= sel_addr;
                        writedata <= sel_wdata;
                        memread   <= ~sel_we & ~addr_bad;
                        memwrite  <= sel_we & ~addr_bad;
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_RESP;
                    memread  <= 1'b0;
                    memwrite <= 1'b0;
                    if (winner == PORT0) begin
                        done0  <= 1'b1;
                        err0_q <= win_bad;
                        if (!win_we && !win_bad) rdata0 <= readdata;
                    end else begin
                        done1  <= 1'b1;
                        err1_q <= win_bad;
                        if (!win_we && !win_bad) rdata1 <= readdata;
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    done0  <= 1'b0;
                    done1  <= 1'b0;
                    err0_q <= 1'b0;
                    err1_q <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    memread  <= 1'b0;
                    memwrite <= 1'b0;
                    done0    <= 1'b0;
                    done1    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of memory contents, grant order and completion timing.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1, memread, memwrite;
    logic [15:0] rdata0, rdata1, address, writedata, readdata;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    logic [15:0] bank[0:DEPTH-1];
    logic [15:0] ref_mem[0:DEPTH-1];
    logic [15:0] exp_rd[2];
    logic        ref_last;
    logic [0:0]  exp_q[$];

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .memread(memread), .memwrite(memwrite), .address(address),
        .writedata(writedata), .readdata(readdata), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Level-sensitive bank: combinational read, write on the clock while memwrite is high.
    assign readdata = (address < DEPTH) ? bank[address[6:0]] : 16'h0000;
    always @(posedge clk) begin
        if (memwrite && address < DEPTH) bank[address[6:0]] <= writedata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [15:0] a);
        return BOUNDS_EN && (a >= DEPTH);
    endfunction

    task automatic issue_chk(input logic w, input logic [15:0] a, input logic [15:0] d);
        chk("issue_state", state_dbg, ST_ISSUE);
        chk("issue_memread", memread, !w && !is_bad(a));
        chk("issue_memwrite", memwrite, w && !is_bad(a));
        chk("issue_address", address, a);
        if (w) chk("issue_writedata", writedata, d);
    endtask

    task automatic at_done(input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (!is_bad(a)) begin
            if (w) ref_mem[a[6:0]] = d;
            else   exp_rd[p] = ref_mem[a[6:0]];
        end
        chk(p ? "rdata1" : "rdata0", p ? rdata1 : rdata0, exp_rd[p]);
        chk(p ? "err1" : "err0", p ? err1 : err0, is_bad(a));
    endtask

    // held_n == 0: each raised port is served once. held_n > 0: both reqs stay
    // high for held_n grants, which must alternate.
    task automatic do_access(input bit r0, input bit r1, input int held_n,
                             input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                             input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        int n;
        int limit;
        int n_done[2];
        logic nxt;
        logic ws[2];
        logic [15:0] as[2], ds[2];
        ws[0] = w0; as[0] = a0; ds[0] = d0;
        ws[1] = w1; as[1] = a1; ds[1] = d1;
        n_done[0] = 0; n_done[1] = 0;
        exp_q.delete();
        if (held_n > 0) begin
            nxt = ~ref_last;
            for (int k = 0; k < held_n; k++) begin
                exp_q.push_back(nxt);
                nxt = ~nxt;
            end
        end else if (r0 && r1) begin
            exp_q.push_back(~ref_last);
            exp_q.push_back(ref_last);
        end else begin
            exp_q.push_back(r1 ? 1'b1 : 1'b0);
        end
        n = exp_q.size();
        limit = 3 * n + 1;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            int k;
            logic ed0, ed1;
            @(negedge clk);
            k = cyc / 3;
            if (cyc % 3 == 1 && k < n) begin
                ref_last = exp_q[k];
                issue_chk(ws[exp_q[k]], as[exp_q[k]], ds[exp_q[k]]);
            end
            ed0 = (cyc % 3 == 2) && (k < n) && (exp_q[k] == 1'b0);
            ed1 = (cyc % 3 == 2) && (k < n) && (exp_q[k] == 1'b1);
            chk("done0", done0, ed0);
            chk("done1", done1, ed1);
            if (ed0 || ed1) begin
                int p;
                p = ed1 ? 1 : 0;
                if ((p ? done1 : done0) === 1'b1) n_done[p]++;
                at_done(p, ws[p], as[p], ds[p]);
                if (held_n == 0) begin
                    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
                end else if (k == n - 1) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (held_n > 0) begin
            chk("fair_port0", n_done[0], held_n / 2);
            chk("fair_port1", n_done[1], held_n - held_n / 2);
        end
    endtask

    task automatic reset_values_chk();
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_err0", err0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_memread", memread, 0);
        chk("rst_memwrite", memwrite, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_state", state_dbg, ST_IDLE);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bank[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        ref_last = 1'b1;

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        reset_values_chk();
        rst = 1'b0;

        // Directed: writes, contention, read-back
        do_access(1, 0, 0, 1'b1, 16'd5, 16'h1234, 1'b0, 16'd0, 16'd0);
        do_access(0, 1, 0, 1'b0, 16'd0, 16'd0, 1'b1, 16'd6, 16'h00AA);
        do_access(1, 1, 0, 1'b0, 16'd5, 16'd0, 1'b0, 16'd6, 16'd0);
        do_access(1, 0, 0, 1'b0, 16'd5, 16'd0, 1'b0, 16'd0, 16'd0);

        // Fairness with both requests held
        do_access(1, 1, 4, 1'b0, 16'd5, 16'd0, 1'b0, 16'd6, 16'd0);

        // Reset in the ISSUE cycle of a port-1 read
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd6;
        @(negedge clk);
        chk("midrst_issue", state_dbg, ST_ISSUE);
        chk("midrst_memread_pre", memread, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_no_done1", done1, 0);
        chk("midrst_state", state_dbg, ST_IDLE);
        chk("midrst_memread", memread, 0);
        rst = 1'b0; req1 = 1'b0;
        ref_last = 1'b1;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        @(negedge clk);
        reset_values_chk();

        // Bounds case (error only when the check is built in)
        if (BOUNDS_EN) begin
            do_access(1, 0, 0, 1'b1, 16'd200, 16'hBEEF, 1'b0, 16'd0, 16'd0);
            do_access(1, 0, 0, 1'b0, 16'd72, 16'd0, 1'b0, 16'd0, 16'd0);
        end

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int pat;
            logic [15:0] ra[2];
            pat = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                if (BOUNDS_EN && $urandom_range(0, 3) == 0) ra[p] = 16'($urandom_range(128, 255));
                else ra[p] = 16'($urandom_range(0, 15));
            end
            do_access(pat[0], pat[1], 0,
                      1'($urandom_range(0, 1)), ra[0], 16'($urandom),
                      1'($urandom_range(0, 1)), ra[1], 16'($urandom));
        end

        // Final sweep: read back a few words on alternating ports
        for (int i = 0; i < 6; i++) begin
            do_access(i % 2 == 0, i % 2 == 1, 0, 1'b0, 16'(i), 16'd0, 1'b0, 16'(i + 6), 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
